// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with two combinational read
// ports, one byte-enabled write port, optional write-to-read bypass and a
// per-register pending-write scoreboard for RAW hazard detection in decode.
// Register 0 is hardwired to zero and is never marked busy.
module regfile_sb #(
    parameter int              DW      = 32,
    parameter int              AW      = 5,
    parameter int              GP_IDX  = 28,
    parameter logic [DW-1:0]   GP_INIT = 32'h0000_1800,
    parameter int              SP_IDX  = 29,
    parameter logic [DW-1:0]   SP_INIT = 32'h0000_2ffc,
    parameter bit              BYPASS  = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [AW-1:0]     A1,
    input  logic [AW-1:0]     A2,
    output logic [DW-1:0]     RD1,
    output logic [DW-1:0]     RD2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              We,
    input  logic [AW-1:0]     A3,
    input  logic [DW/8-1:0]   BE,
    input  logic [DW-1:0]     WD,
    input  logic              SetEn,
    input  logic [AW-1:0]     SetA,
    output logic [AW:0]       PendCnt
);

    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [AW:0]      pend_cnt;

    logic             wr_hit;
    logic             set_hit;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             byp1;
    logic             byp2;

    // Bytes with be=1 come from new_v, the rest keep old_v.
    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Qualify requests: anything addressed to register 0 is dropped.
    always_comb begin
        wr_hit  = We && (A3 != '0);
        set_hit = SetEn && (SetA != '0);
    end

    // Count only real busy transitions. A set on an idle register adds one;
    // a clear of a busy register subtracts one unless a set on the same
    // register in this cycle keeps it busy (new producer supersedes old).
    always_comb begin
        cnt_inc = set_hit && !busy[SetA];
        cnt_dec = wr_hit && busy[A3] && !(set_hit && (SetA == A3));
    end

    // Register storage: reset loads GP/SP init values, writes merge bytes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == GP_IDX) begin
                    regs[i] <= GP_INIT;
                end else if (i == SP_IDX) begin
                    regs[i] <= SP_INIT;
                end else begin
                    regs[i] <= '0;
                end
            end
        end else if (wr_hit) begin
            regs[A3] <= byte_merge(regs[A3], WD, BE);
        end
    end

    // Scoreboard: clear on writeback, then set on issue so set wins a tie.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            busy <= '0;
        end else begin
            if (wr_hit) begin
                busy[A3] <= 1'b0;
            end
            if (set_hit) begin
                busy[SetA] <= 1'b1;
            end
        end
    end

    // Pending counter tracks the population count of busy incrementally.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pend_cnt <= '0;
        end else begin
            pend_cnt <= pend_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

    // Bypass selects: a same-cycle write to the addressed register.
    always_comb begin
        byp1 = BYPASS && wr_hit && (A1 == A3);
        byp2 = BYPASS && wr_hit && (A2 == A3);
    end

    // Read port 1: zero for r0, merged write data on bypass, else stored.
    always_comb begin
        RD1   = regs[A1];
        Busy1 = busy[A1];
        if (A1 == '0) begin
            RD1   = '0;
            Busy1 = 1'b0;
        end else if (byp1) begin
            RD1   = byte_merge(regs[A1], WD, BE);
            Busy1 = 1'b0;
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        RD2   = regs[A2];
        Busy2 = busy[A2];
        if (A2 == '0) begin
            RD2   = '0;
            Busy2 = 1'b0;
        end else if (byp2) begin
            RD2   = byte_merge(regs[A2], WD, BE);
            Busy2 = 1'b0;
        end
    end

    assign PendCnt = pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed plan steps followed by random traffic,
// checked against an array-based reference model. Two instances share all
// inputs: one with bypass, one without.
module tb_regfile_sb;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  A1, A2, A3, SetA;
    logic        We, SetEn;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] RD1, RD2, RD1_nb, RD2_nb;
    logic        Busy1, Busy2, Busy1_nb, Busy2_nb;
    logic [5:0]  PendCnt, PendCnt_nb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    always #5 Clk = ~Clk;

    regfile_sb #(.BYPASS(1'b1)) dut (
        .Clk(Clk), .Rst(Rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .Busy1(Busy1), .Busy2(Busy2), .We(We), .A3(A3), .BE(BE), .WD(WD),
        .SetEn(SetEn), .SetA(SetA), .PendCnt(PendCnt)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .Rst(Rst), .A1(A1), .A2(A2), .RD1(RD1_nb), .RD2(RD2_nb),
        .Busy1(Busy1_nb), .Busy2(Busy2_nb), .We(We), .A3(A3), .BE(BE), .WD(WD),
        .SetEn(SetEn), .SetA(SetA), .PendCnt(PendCnt_nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_reg[28] = 32'h0000_1800;
        m_reg[29] = 32'h0000_2ffc;
    endtask

    function automatic int model_pend();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = m_reg[a];
        if (byp && We && A3 != 0 && a == A3) begin
            for (int b = 0; b < 4; b++)
                if (BE[b]) v[8*b +: 8] = WD[8*b +: 8];
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (byp && We && A3 != 0 && a == A3) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_edge();
        if (Rst) begin
            model_reset();
        end else begin
            if (We && A3 != 0) begin
                for (int b = 0; b < 4; b++)
                    if (BE[b]) m_reg[A3][8*b +: 8] = WD[8*b +: 8];
                m_busy[A3] = 1'b0;
            end
            if (SetEn && SetA != 0) m_busy[SetA] = 1'b1;
        end
    endtask

    // Inputs are already driven (just after a negedge). Check all outputs
    // against the model, then step through the next rising edge.
    task automatic cycle(input string tag);
        if (Rst) model_reset();
        #1;
        check({tag, ":rd1"},    RD1,      exp_rd(A1, 1'b1));
        check({tag, ":rd2"},    RD2,      exp_rd(A2, 1'b1));
        check({tag, ":busy1"},  {31'h0, Busy1}, {31'h0, exp_busy(A1, 1'b1)});
        check({tag, ":busy2"},  {31'h0, Busy2}, {31'h0, exp_busy(A2, 1'b1)});
        check({tag, ":rd1_nb"}, RD1_nb,   exp_rd(A1, 1'b0));
        check({tag, ":rd2_nb"}, RD2_nb,   exp_rd(A2, 1'b0));
        check({tag, ":busy1_nb"}, {31'h0, Busy1_nb}, {31'h0, exp_busy(A1, 1'b0)});
        check({tag, ":busy2_nb"}, {31'h0, Busy2_nb}, {31'h0, exp_busy(A2, 1'b0)});
        check({tag, ":pend"},    {26'h0, PendCnt},    model_pend());
        check({tag, ":pend_nb"}, {26'h0, PendCnt_nb}, model_pend());
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    task automatic idle();
        We = 1'b0; SetEn = 1'b0; A3 = 5'd0; SetA = 5'd0; BE = 4'h0; WD = 32'h0;
    endtask

    initial begin
        model_reset();
        idle();
        Rst = 1'b1; A1 = 5'd28; A2 = 5'd29;

        // Reset state
        #1;
        check("rst_gp",    RD1, 32'h0000_1800);
        check("rst_sp",    RD2, 32'h0000_2ffc);
        check("rst_pend",  {26'h0, PendCnt}, 32'd0);
        check("rst_busy",  {30'h0, Busy1, Busy2}, 32'd0);
        cycle("reset");
        A1 = 5'd5;
        #1;
        check("rst_r5", RD1, 32'h0);
        Rst = 1'b0;
        cycle("rst_release");

        // Preload reg5, then partial byte write with bypass
        We = 1'b1; A3 = 5'd5; BE = 4'hf; WD = 32'h1122_3344;
        cycle("preload5");
        BE = 4'b0101; WD = 32'hAABB_CCDD; A1 = 5'd5; A2 = 5'd5;
        #1;
        check("be_byp",   RD1,    32'h11BB_33DD);
        check("be_nobyp", RD1_nb, 32'h1122_3344);
        cycle("be_write");
        idle();
        #1;
        check("be_after",    RD1,    32'h11BB_33DD);
        check("be_after_nb", RD1_nb, 32'h11BB_33DD);
        cycle("be_after");

        // Register 0 is hardwired
        We = 1'b1; A3 = 5'd0; BE = 4'hf; WD = 32'hFFFF_FFFF; SetEn = 1'b1; SetA = 5'd0;
        A1 = 5'd0;
        cycle("r0_write");
        idle();
        #1;
        check("r0_rd",   RD1, 32'h0);
        check("r0_busy", {31'h0, Busy1}, 32'd0);
        check("r0_pend", {26'h0, PendCnt}, 32'd0);
        cycle("r0_after");

        // Scoreboard set and clear on reg 7
        SetEn = 1'b1; SetA = 5'd7; A1 = 5'd7;
        cycle("set7");
        idle();
        #1;
        check("set7_busy", {31'h0, Busy1}, 32'd1);
        check("set7_pend", {26'h0, PendCnt}, 32'd1);
        We = 1'b1; A3 = 5'd7; BE = 4'hf; WD = 32'h0000_0077;
        #1;
        check("clr7_byp_busy",   {31'h0, Busy1},    32'd0);
        check("clr7_nobyp_busy", {31'h0, Busy1_nb}, 32'd1);
        cycle("clr7");
        idle();
        #1;
        check("clr7_pend", {26'h0, PendCnt}, 32'd0);
        cycle("clr7_after");

        // Simultaneous set/clear on reg 9, then set 3 with write 9
        SetEn = 1'b1; SetA = 5'd9; A1 = 5'd9; A2 = 5'd3;
        cycle("set9");
        We = 1'b1; A3 = 5'd9; BE = 4'hf; WD = 32'h99;
        cycle("set_clr9");
        idle();
        #1;
        check("setclr9_busy", {31'h0, Busy1_nb}, 32'd1);
        check("setclr9_pend", {26'h0, PendCnt}, 32'd1);
        SetEn = 1'b1; SetA = 5'd3; We = 1'b1; A3 = 5'd9; BE = 4'hf; WD = 32'h9a;
        cycle("set3_clr9");
        idle();
        #1;
        check("s3c9_busy9", {31'h0, Busy1}, 32'd0);
        check("s3c9_busy3", {31'h0, Busy2}, 32'd1);
        check("s3c9_pend",  {26'h0, PendCnt}, 32'd1);
        We = 1'b1; A3 = 5'd3; BE = 4'hf; WD = 32'h33;
        cycle("clr3");

        // Reset mid-operation with regs 4 and 6 busy
        idle(); SetEn = 1'b1; SetA = 5'd4;
        cycle("set4");
        SetA = 5'd6;
        cycle("set6");
        idle(); A1 = 5'd4; A2 = 5'd6;
        #1;
        check("mid_pend2", {26'h0, PendCnt}, 32'd2);
        We = 1'b1; A3 = 5'd4; BE = 4'hf; WD = 32'hDEAD_BEEF;
        Rst = 1'b1;
        cycle("mid_rst");
        Rst = 1'b0; idle();
        #1;
        check("mid_r4",   RD1, 32'h0);
        check("mid_pend", {26'h0, PendCnt}, 32'd0);
        cycle("mid_after");

        // Random traffic, biased to a few registers to provoke collisions
        for (int n = 0; n < 400; n++) begin
            A1    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            A2    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            A3    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            SetA  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            We    = $urandom_range(0, 1) != 0;
            SetEn = $urandom_range(0, 1) != 0;
            BE    = 4'($urandom_range(0, 15));
            WD    = $urandom;
            Rst   = $urandom_range(0, 63) == 0;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the pipelined CPU. It has two combinational read ports and one byte-enabled write port, with optional write-to-read bypass. A per-register pending-write scoreboard lets the decode stage detect RAW hazards against in-flight producers, such as loads and multi-cycle ops, without an external hazard table. It sits between decode, whose reads and scoreboard sets happen in ID, and writeback, whose writes and scoreboard clears happen in WB.

## Interface
Parameters:
- DW, 32, data width; must be a multiple of 8
- AW, 5, address width; depth is 2**AW
- GP_IDX, 28, index of the global-pointer register
- GP_INIT, 32'h0000_1800, reset value of register GP_IDX
- SP_IDX, 29, index of the stack-pointer register
- SP_INIT, 32'h0000_2ffc, reset value of register SP_IDX
- BYPASS, 1, 1 = same-cycle write data is visible on the read ports; 0 = read returns the stored value

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, asynchronous, active-high
- A1  in  AW  read port 1 address
- A2  in  AW  read port 2 address
- RD1  out  DW  read port 1 data
- RD2  out  DW  read port 2 data
- Busy1  out  1  register A1 has a pending write
- Busy2  out  1  register A2 has a pending write
- We  in  1  write enable
- A3  in  AW  write address
- BE  in  DW/8  byte enables for the write; bit i covers WD[8i+7:8i]
- WD  in  DW  write data
- SetEn  in  1  mark register SetA as pending (producer issued)
- SetA  in  AW  register to mark pending
- PendCnt  out  AW+1  number of registers currently marked pending

## Operation
- Storage: 2**AW x DW registers plus a 2**AW-bit busy vector. Register 0 is hardwired:
  - reads as 0 and is never busy;
  - writes, sets and clears to index 0 are ignored.
- Write: on a rising Clk edge with We=1 and A3!=0, update byte i of reg[A3] to WD byte i for each BE[i]=1; bytes with BE[i]=0 keep their value. We=1 with BE=0 leaves the data unchanged but still clears busy.
- Scoreboard clear: a write (We=1, A3!=0) clears busy[A3] at the same edge.
- Scoreboard set: SetEn=1 and SetA!=0 sets busy[SetA] at the edge. Setting an already-busy register leaves it busy; there is no count per register.
- Simultaneous set and clear of the same register: set wins and busy stays 1, because the new producer supersedes the old one.
- Set and clear on different registers in the same cycle: both take effect.
- PendCnt: a registered population count of the busy vector, updated incrementally each edge by +1, -1, 0 or 0 (set+clear) according to the actual busy transitions.
  - Never underflows: a clear of a non-busy register does not decrement.
  - Never exceeds 2**AW-1, since reg 0 is never busy.
- Read, BYPASS=1: when We=1, A3!=0 and A1==A3, RD1 is the byte merge of WD (bytes with BE=1) and reg[A1] (others), and Busy1=busy[A1] AND NOT(the write clears it). A same-cycle set of A1 still shows Busy1=0 until the next cycle, because sets are visible from the next cycle. Port 2 behaves identically.
- Read, BYPASS=0: RD1=reg[A1] and Busy1=busy[A1], both pure stored state.
- Reset: every register is set to 0, except GP_IDX=GP_INIT and SP_IDX=SP_INIT. All busy bits are 0 and PendCnt=0. RD/Busy then follow combinationally from the reset state.
- Reset asserted mid-operation overrides any same-cycle write or set. Deassertion takes effect at the first edge after Rst falls.

## Timing
- Read ports are combinational from A1, A2 and the stored state, plus We, A3, BE and WD when BYPASS=1. There are no clocked read paths.
- Write/set/clear latency: 1 cycle. The stored value and busy bit are visible at the next edge.
- PendCnt is registered and reflects busy state after the same edge.
- No handshakes are used. All requests are accepted unconditionally each cycle.

## Test plan
- Reset: assert Rst async between edges -> RD1 with A1=28 reads 32'h0000_1800; A2=29 reads 32'h0000_2ffc; A1=5 reads 0; PendCnt=0; Busy1=Busy2=0.
- Byte-enable write and bypass: preload reg5=32'h1122_3344, then drive We=1, A3=5, BE=4'b0101, WD=32'hAABB_CCDD. During that cycle RD1 (A1=5, BYPASS=1) must read 32'h11BB_33DD; the next cycle reads the same. With BYPASS=0, the same cycle reads 32'h1122_3344.
- Register 0: drive We=1, A3=0, WD=32'hFFFF_FFFF and SetEn=1, SetA=0 -> RD1 (A1=0) reads 0, Busy1=0, PendCnt unchanged.
- Scoreboard: set reg7 -> next cycle Busy1 (A1=7)=1 and PendCnt=1. A write to 7 with BYPASS=1 gives Busy1=0 in the write cycle; afterwards PendCnt=0.
- Simultaneous events: with reg9 busy, set 9 and write 9 in the same cycle -> Busy remains 1 and PendCnt unchanged. Set 3 and write 9 together with 9 busy -> busy3=1, busy9=0, PendCnt unchanged.
- Reset mid-operation: with regs 4 and 6 busy (PendCnt=2), assert Rst coincident with We=1, A3=4 -> reg4=0, PendCnt=0, no write landed.
